// File: rtl/rr_mux_reg_if.sv
// Handshake bundle for rr_mux_reg: N producer channels into one registered consumer port.
// The master side drives channels, mode/sel and out_ready; the slave side is the mux.
interface rr_mux_reg_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic                  mode;
    logic [SELW-1:0]       sel;
    logic [NCH*WIDTH-1:0]  in_data;
    logic [NCH-1:0]        in_valid;
    logic [NCH-1:0]        in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SELW-1:0]       out_ch;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/rr_mux_reg.sv
// N-channel registered mux with fixed-select or round-robin arbitration and a single
// output register that sustains one word per clock when the consumer is always ready.
module rr_mux_reg #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_mux_reg_if.slave bus
);
    logic [WIDTH-1:0] data_p1;
    logic [SELW-1:0]  ch_p1;
    logic             vld_p1;
    logic [SELW-1:0]  ptr;

    logic             load;
    logic [NCH-1:0]   grant;
    logic [SELW-1:0]  gidx;
    logic             gany;
    logic [WIDTH-1:0] sel_data;

    assign load = !vld_p1 || bus.out_ready;

    // Round-robin scans ptr..NCH-1 first, then wraps to 0..ptr-1.
    always_comb begin
        grant    = '0;
        gidx     = '0;
        gany     = 1'b0;
        sel_data = '0;
        if (!bus.mode) begin
            for (int i = 0; i < NCH; i++) begin
                if (SELW'(i) == bus.sel && bus.in_valid[i]) begin
                    grant[i] = 1'b1;
                    gidx     = SELW'(i);
                    gany     = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!gany && bus.in_valid[i] && SELW'(i) >= ptr) begin
                    grant[i] = 1'b1;
                    gidx     = SELW'(i);
                    gany     = 1'b1;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (!gany && bus.in_valid[i] && SELW'(i) < ptr) begin
                    grant[i] = 1'b1;
                    gidx     = SELW'(i);
                    gany     = 1'b1;
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                sel_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.in_ready = (rst_n && load) ? grant : '0;

    // Stage boundary: grant -> output register (p1).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ch_p1   <= '0;
            ptr     <= '0;
        end else if (load) begin
            vld_p1 <= gany;
            if (gany) begin
                data_p1 <= sel_data;
                ch_p1   <= gidx;
                if (bus.mode) begin
                    ptr <= (gidx == SELW'(NCH-1)) ? '0 : gidx + 1'b1;
                end
            end
        end
    end

    assign bus.out_data  = data_p1;
    assign bus.out_ch    = ch_p1;
    assign bus.out_valid = vld_p1;
endmodule
